// File: rtl/cpu_mmio_pkg.sv
// Shared definitions for Cpu data-port peripherals: register offsets, MemSize codes,
// UART transmitter state encoding and STATUS bit positions.
package cpu_mmio_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int STAT_FULL     = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_COUNT_LO = 3;
  localparam int STAT_OVERFLOW = 6;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. A push while full is dropped even when
// the same cycle pops, because fullness is judged on the pre-pop count.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the Cpu data port (TXDATA/STATUS/BAUDDIV).
// Define UART_PARITY_EN to insert an even-parity bit after the data bits.
module mmio_uart_tx
  import cpu_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] CLKS_PER_BIT = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [2:0]  size,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        sel,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e state_q, state_d;
  logic [2:0]  bit_idx_q, bit_idx_d, next_idx;
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [15:0] baud_q, baud_d;
  logic        ovf_q, ovf_d;

  logic [3:0]    offset;
  logic          wr_en, push, clr_ovf, baud_we, bit_end, fifo_pop;
  logic [15:0]   div_eff;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [31:0]   status_word;
  logic          unused_wd_hi;

  assign offset       = A[3:0];
  assign sel          = (A[31:4] == BASE_ADDR[31:4]);
  assign wr_en        = sel & WE;
  assign push         = wr_en & (offset == OFF_TXDATA);
  assign clr_ovf      = wr_en & (offset == OFF_STATUS);
  assign baud_we      = wr_en & (offset == OFF_BAUDDIV) & (size == SIZE_W);
  assign div_eff      = (baud_q == 16'd0) ? 16'd1 : baud_q;
  assign bit_end      = (cyc_q == div_q - 16'd1);
  assign next_idx     = bit_idx_q + 3'd1;
  assign tx           = tx_q;
  assign unused_wd_hi = ^WD[31:16];

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (WD[7:0]),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status_word                         = '0;
    status_word[STAT_FULL]              = fifo_full;
    status_word[STAT_EMPTY]             = fifo_empty;
    status_word[STAT_BUSY]              = (state_q != IDLE);
    status_word[STAT_COUNT_LO +: 3]     = 3'(fifo_count);
    status_word[STAT_OVERFLOW]          = ovf_q;
    RD = '0;
    if (sel) begin
      case (offset)
        OFF_STATUS:  RD = status_word;
        OFF_BAUDDIV: RD = {16'h0000, baud_q};
        default:     RD = '0;
      endcase
    end
  end

  // Overflow clears on any STATUS write; a drop can't coincide since it needs a TXDATA write.
  always_comb begin
    baud_d = baud_q;
    ovf_d  = ovf_q;
    if (baud_we) baud_d = WD[15:0];
    if (clr_ovf) ovf_d = 1'b0;
    else if (push & fifo_full) ovf_d = 1'b1;
  end

  // Each bit's length is latched into div_q as the bit begins, so BAUDDIV writes wait for the next bit.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    cyc_d     = cyc_q;
    div_d     = div_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    if (state_q != IDLE) cyc_d = bit_end ? 16'd0 : cyc_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = START;
          tx_d     = 1'b0;
          cyc_d    = 16'd0;
          div_d    = div_eff;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          div_d     = div_eff;
        end
      end
      DATA: begin
        if (bit_end) begin
          div_d     = div_eff;
          bit_idx_d = next_idx;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
            tx_d    = ^shift_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[next_idx];
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
          div_d   = div_eff;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          div_d = div_eff;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = START;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_idx_q <= 3'd0;
      cyc_q     <= 16'd0;
      div_q     <= 16'd1;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      baud_q    <= CLKS_PER_BIT;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      cyc_q     <= cyc_d;
      div_q     <= div_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      baud_q    <= baud_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
